// File: rtl/decoder_scan_seq.sv
// decoder_scan_seq: drives sel/en of a downstream 2-to-4 decoder so the four
// one-hot outputs are activated one at a time, each held for a latched dwell
// time, optionally separated by en=0 blanking cycles, skipping masked channels.
// Optional feature macro: SCAN_WRAP_PULSE_EN adds a one-cycle wrap_pulse output
// that marks the start of each new sweep.
//
// Handshake: start is a level sampled only in IDLE; stop is a level sampled
// every cycle while busy and remembered until the current dwell ends. There is
// no ready signal; busy=1 means further starts are ignored.
module decoder_scan_seq #(
    parameter int DWELL_W      = 8,
    parameter int BLANK_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [3:0]         ch_mask,
    output logic [1:0]         sel,
    output logic               en,
    output logic               busy,
`ifdef SCAN_WRAP_PULSE_EN
    output logic               wrap_pulse,
`endif
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2
    } state_t;

    localparam int BW = (BLANK_CYCLES < 2) ? 1 : $clog2(BLANK_CYCLES + 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES);

    state_t             state, state_n;
    logic [1:0]         sel_n;
    logic               en_n, busy_n;
    logic [DWELL_W-1:0] dwell_lat, dwell_lat_n;
    logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_n;
    logic [BW-1:0]      blank_cnt, blank_cnt_n;
    logic               stop_req, stop_req_n;
    logic [1:0]         nxt;
`ifdef SCAN_WRAP_PULSE_EN
    logic               wrap_n;
`endif

    // Lowest set bit of the mask; the caller guarantees the mask is non-zero.
    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Next set bit above cur, wrapping 3->0; falls back to cur itself last.
    function automatic logic [1:0] next_ch(input logic [3:0] m, input logic [1:0] cur);
        logic [1:0] idx;
        logic [1:0] cand;
        logic       found;
        idx   = cur;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = cur + 2'(i);
            if (!found && m[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    assign dbg_state = state;

    // Next-state and registered-output computation for the scan FSM.
    always_comb begin
        state_n     = state;
        sel_n       = sel;
        en_n        = en;
        busy_n      = busy;
        dwell_lat_n = dwell_lat;
        dwell_cnt_n = dwell_cnt;
        blank_cnt_n = blank_cnt;
        stop_req_n  = stop_req;
`ifdef SCAN_WRAP_PULSE_EN
        wrap_n      = 1'b0;
`endif
        nxt         = next_ch(ch_mask, sel);

        case (state)
            IDLE: begin
                // stop in the same cycle as start wins
                if (start && !stop && (ch_mask != 4'b0000)) begin
                    state_n     = ACTIVE;
                    dwell_lat_n = (dwell == '0) ? DWELL_W'(1) : dwell;
                    sel_n       = lowest_ch(ch_mask);
                    en_n        = 1'b1;
                    busy_n      = 1'b1;
                    dwell_cnt_n = DWELL_W'(1);
                    stop_req_n  = 1'b0;
                end
            end

            ACTIVE: begin
                stop_req_n = stop_req | stop;
                // dwell_cnt counts en=1 cycles already shown, starting at 1
                if (dwell_cnt == dwell_lat) begin
                    if (stop_req || stop || (ch_mask == 4'b0000)) begin
                        state_n     = IDLE;
                        en_n        = 1'b0;
                        busy_n      = 1'b0;
                        stop_req_n  = 1'b0;
                        dwell_cnt_n = '0;
                    end else begin
                        sel_n = nxt;
`ifdef SCAN_WRAP_PULSE_EN
                        wrap_n = (nxt <= sel);
`endif
                        if (BLANK_CYCLES > 0) begin
                            // sel moves while en=0 so the decode never glitches
                            state_n     = BLANK;
                            en_n        = 1'b0;
                            blank_cnt_n = BW'(1);
                            dwell_cnt_n = '0;
                        end else begin
                            dwell_cnt_n = DWELL_W'(1);
                        end
                    end
                end else begin
                    dwell_cnt_n = dwell_cnt + DWELL_W'(1);
                end
            end

            BLANK: begin
                stop_req_n = stop_req | stop;
                if (blank_cnt == BLANK_LAST) begin
                    state_n     = ACTIVE;
                    en_n        = 1'b1;
                    blank_cnt_n = '0;
                    dwell_cnt_n = DWELL_W'(1);
                end else begin
                    blank_cnt_n = blank_cnt + BW'(1);
                end
            end

            default: begin
                state_n = IDLE;
                en_n    = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops en immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= 2'b00;
            en        <= 1'b0;
            busy      <= 1'b0;
            dwell_lat <= '0;
            dwell_cnt <= '0;
            blank_cnt <= '0;
            stop_req  <= 1'b0;
        end else begin
            state     <= state_n;
            sel       <= sel_n;
            en        <= en_n;
            busy      <= busy_n;
            dwell_lat <= dwell_lat_n;
            dwell_cnt <= dwell_cnt_n;
            blank_cnt <= blank_cnt_n;
            stop_req  <= stop_req_n;
        end
    end

`ifdef SCAN_WRAP_PULSE_EN
    // One-cycle marker for the sel update that starts a new sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wrap_pulse <= 1'b0;
        else     wrap_pulse <= wrap_n;
    end
`endif

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Bench for decoder_scan_seq (DWELL_W=8, BLANK_CYCLES=1). Each scenario pushes
// the expected per-cycle {wrap, busy, en, sel} trace into a queue, then steps
// the clock and pops one entry per cycle, sampling 1 ns after the rising edge.
module tb_decoder_scan_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [7:0] dwell;
    logic [3:0] ch_mask;
    logic [1:0] sel;
    logic       en;
    logic       busy;
    logic [1:0] dbg_state;
`ifdef SCAN_WRAP_PULSE_EN
    logic       wrap_pulse;
`endif

    logic [4:0] exp_q[$];
    int tests;
    int fails;

    decoder_scan_seq #(.DWELL_W(8), .BLANK_CYCLES(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .dwell     (dwell),
        .ch_mask   (ch_mask),
        .sel       (sel),
        .en        (en),
        .busy      (busy),
`ifdef SCAN_WRAP_PULSE_EN
        .wrap_pulse(wrap_pulse),
`endif
        .dbg_state (dbg_state)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] observed();
`ifdef SCAN_WRAP_PULSE_EN
        return {wrap_pulse, busy, en, sel};
`else
        return {1'b0, busy, en, sel};
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic b, input logic e, input logic [1:0] s, input logic w);
`ifdef SCAN_WRAP_PULSE_EN
        exp_q.push_back({w, b, e, s});
`else
        exp_q.push_back({1'b0, b, e, s});
`endif
    endtask

    task automatic push_dwell(input logic [1:0] ch, input int d);
        for (int i = 0; i < d; i++) push(1'b1, 1'b1, ch, 1'b0);
    endtask

    task automatic push_blank(input logic [1:0] ch, input logic w);
        push(1'b1, 1'b0, ch, w);
    endtask

    task automatic push_idle(input logic [1:0] ch, input int n);
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, ch, 1'b0);
    endtask

    task automatic test_reset();
        logic [4:0] got;
        #2 rst = 1'b1;
        #1;
        tests++;
        if (sel !== 2'b00) begin fails++; $display("FAIL reset_async_sel: got %b expected 00", sel); end
        tests++;
        if (en !== 1'b0) begin fails++; $display("FAIL reset_async_en: got %b expected 0", en); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_async_busy: got %b expected 0", busy); end
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            got = observed();
            tests++;
            if (got !== 5'b00000) begin
                fails++;
                $display("FAIL reset_idle cycle %0d: got %b expected 00000", k, got);
            end
        end
    endtask

    task automatic test_full_scan();
        logic [4:0] got, exp;
        int n;
        exp_q.delete();
        push_dwell(2'd0, 3); push_blank(2'd1, 1'b0);
        push_dwell(2'd1, 3); push_blank(2'd2, 1'b0);
        push_dwell(2'd2, 3); push_blank(2'd3, 1'b0);
        push_dwell(2'd3, 3); push_blank(2'd0, 1'b1);
        push_dwell(2'd0, 3); push_idle(2'd0, 2);
        dwell = 8'd3; ch_mask = 4'b1111; start = 1'b1;
        step();
        start = 1'b0;
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            got = observed();
            exp = exp_q.pop_front();
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL full_scan cycle %0d: got %b expected %b", k, got, exp);
            end
            stop = (k == 16);
            step();
        end
        stop = 1'b0;
    endtask

    task automatic test_masked_scan();
        logic [4:0] got, exp;
        int n;
        exp_q.delete();
        push_dwell(2'd1, 2); push_blank(2'd3, 1'b0);
        push_dwell(2'd3, 2); push_blank(2'd1, 1'b1);
        push_dwell(2'd1, 2); push_blank(2'd3, 1'b0);
        push_dwell(2'd3, 2); push_idle(2'd3, 2);
        dwell = 8'd2; ch_mask = 4'b1010; start = 1'b1;
        step();
        start = 1'b0;
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            got = observed();
            exp = exp_q.pop_front();
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL masked_scan cycle %0d: got %b expected %b", k, got, exp);
            end
            // stop raised during BLANK: one more full dwell still runs
            stop = (k == 8);
            step();
        end
        stop = 1'b0;
    endtask

    task automatic test_edges();
        logic [4:0] got, exp;
        int n;
        // dwell=0 behaves as dwell=1; stop on the switch cycle ends the scan
        exp_q.delete();
        push_dwell(2'd0, 1); push_blank(2'd1, 1'b0);
        push_dwell(2'd1, 1); push_blank(2'd2, 1'b0);
        push_dwell(2'd2, 1); push_blank(2'd3, 1'b0);
        push_dwell(2'd3, 1); push_blank(2'd0, 1'b1);
        push_dwell(2'd0, 1); push_idle(2'd0, 2);
        dwell = 8'd0; ch_mask = 4'b1111; start = 1'b1;
        step();
        start = 1'b0;
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            got = observed();
            exp = exp_q.pop_front();
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL dwell_zero cycle %0d: got %b expected %b", k, got, exp);
            end
            stop = (k == 8);
            step();
        end
        stop = 1'b0;

        // start with an empty mask is ignored
        dwell = 8'd2; ch_mask = 4'b0000; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            got = observed();
            tests++;
            if (got !== 5'b00000) begin
                fails++;
                $display("FAIL start_mask_zero cycle %0d: got %b expected 00000", k, got);
            end
            step();
        end

        // start together with stop: stop wins
        ch_mask = 4'b1111; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            got = observed();
            tests++;
            if (got !== 5'b00000) begin
                fails++;
                $display("FAIL start_and_stop cycle %0d: got %b expected 00000", k, got);
            end
            step();
        end

        // single channel reselects itself; empty mask at a switch ends the scan
        exp_q.delete();
        push_dwell(2'd2, 1); push_blank(2'd2, 1'b1);
        push_dwell(2'd2, 1); push_blank(2'd2, 1'b1);
        push_dwell(2'd2, 1); push_idle(2'd2, 2);
        dwell = 8'd1; ch_mask = 4'b0100; start = 1'b1;
        step();
        start = 1'b0;
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            got = observed();
            exp = exp_q.pop_front();
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL single_channel cycle %0d: got %b expected %b", k, got, exp);
            end
            if (k == 4) ch_mask = 4'b0000;
            step();
        end
    endtask

    task automatic test_stop_mid_dwell();
        logic [4:0] got, exp;
        int n;
        exp_q.delete();
        push_dwell(2'd0, 4); push_blank(2'd1, 1'b0);
        push_dwell(2'd1, 4); push_idle(2'd1, 3);
        dwell = 8'd4; ch_mask = 4'b1111; start = 1'b1;
        step();
        start = 1'b0;
        // dwell is latched at start; a later change must not affect this scan
        dwell = 8'd1;
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            got = observed();
            exp = exp_q.pop_front();
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL stop_mid_dwell cycle %0d: got %b expected %b", k, got, exp);
            end
            stop = (k == 6);
            start = (k == 2);
            step();
        end
        stop = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        logic [4:0] got, exp;
        int n;
        exp_q.delete();
        push_dwell(2'd0, 2); push_blank(2'd1, 1'b0);
        push_dwell(2'd1, 2); push_blank(2'd2, 1'b0);
        dwell = 8'd2; ch_mask = 4'b1111; start = 1'b1;
        step();
        start = 1'b0;
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            got = observed();
            exp = exp_q.pop_front();
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL pre_reset cycle %0d: got %b expected %b", k, got, exp);
            end
            step();
        end
        got = observed();
        tests++;
        if (got[3:0] !== 4'b1110) begin
            fails++;
            $display("FAIL channel2_active: got %b expected 1110", got[3:0]);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (en !== 1'b0) begin fails++; $display("FAIL reset_mid_en: got %b expected 0", en); end
        tests++;
        if ({busy, sel} !== 3'b000) begin
            fails++;
            $display("FAIL reset_mid_busy_sel: got %b expected 000", {busy, sel});
        end
        step();
        rst = 1'b0;
        step();

        exp_q.delete();
        push_dwell(2'd1, 3); push_idle(2'd1, 2);
        dwell = 8'd3; ch_mask = 4'b1110; start = 1'b1;
        step();
        start = 1'b0;
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            got = observed();
            exp = exp_q.pop_front();
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL restart_after_reset cycle %0d: got %b expected %b", k, got, exp);
            end
            stop = (k == 0);
            step();
        end
        stop = 1'b0;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst     = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        dwell   = 8'($urandom_range(1, 255));
        ch_mask = 4'($urandom_range(0, 15));
        test_reset();
        test_full_scan();
        test_masked_scan();
        test_edges();
        test_stop_mid_dwell();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
